// File: rtl/udcount_pkg.sv
// Shared constants and the load clamp helper for the udcount_lim counter family.
package udcount_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int CLAMP_W = 32;

  // Lower bound is applied before the upper bound, so inverted limits yield hi.
  function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] value,
                                               input logic [CLAMP_W-1:0] lo,
                                               input logic [CLAMP_W-1:0] hi);
    logic [CLAMP_W-1:0] t;
    t = (value < lo) ? lo : value;
    t = (t > hi) ? hi : t;
    return t;
  endfunction

endpackage

// File: rtl/udcount_prescaler.sv
// Enabled-cycle divider: tick every presc+1 enabled cycles, restartable.
module udcount_prescaler
  import udcount_pkg::*;
#(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             restart,
  input  logic [PRE_W-1:0] presc,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  assign tick = en & ~restart & (cnt == presc);

  // A cnt above a freshly lowered presc falls back to 0 without ticking.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt >= presc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/udcount_lim.sv
// Up/down counter with programmable limits, wrap/saturate mode, clamped load,
// sticky over/underflow flags and a built-in prescaler.
module udcount_lim
  import udcount_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [PRE_W-1:0] presc,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             ovf,
  output logic             unf,
  output logic             load_err,
  output logic             cfg_err
);

  logic             tick;
  logic             step;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             load_err_nxt;
  logic             ovf_hit;
  logic             unf_hit;

  udcount_prescaler #(.PRE_W(PRE_W)) u_presc (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .restart (clr | load_en),
    .presc   (presc),
    .tick    (tick)
  );

  assign cfg_err  = (min_val > max_val);
  assign at_max   = (count == max_val);
  assign at_min   = (count == min_val);
  assign step     = en & tick & ~cfg_err;
  assign load_val = WIDTH'(clamp(CLAMP_W'(load), CLAMP_W'(min_val), CLAMP_W'(max_val)));

  always_comb begin
    count_nxt    = count;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    ovf_hit      = 1'b0;
    unf_hit      = 1'b0;
    if (clr) begin
      count_nxt = min_val;
    end else if (load_en) begin
      count_nxt    = load_val;
      load_err_nxt = (load_val != load);
    end else if (step) begin
      // Limits moved under the count: pull it back in, no flags.
      if (count > max_val) begin
        count_nxt = max_val;
      end else if (count < min_val) begin
        count_nxt = min_val;
      end else if (down == DIR_UP) begin
        if (!at_max) begin
          count_nxt = count + WIDTH'(1);
        end else begin
          ovf_hit = 1'b1;
          if (sat_mode == MODE_WRAP) begin
            count_nxt = min_val;
            wrap_nxt  = 1'b1;
          end
        end
      end else begin
        if (!at_min) begin
          count_nxt = count - WIDTH'(1);
        end else begin
          unf_hit = 1'b1;
          if (sat_mode == MODE_WRAP) begin
            count_nxt = max_val;
            wrap_nxt  = 1'b1;
          end
        end
      end
    end
  end

  // A new hit outranks flag_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      count    <= count_nxt;
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
      ovf      <= ovf_hit | (ovf & ~flag_clr);
      unf      <= unf_hit | (unf & ~flag_clr);
    end
  end

endmodule

// File: doc/udcount_lim.md
# udcount_lim

Parametrised up/down counter with programmable lower/upper limits, wrap or saturate mode, and a built-in prescaler. It is the general-purpose successor to the team's fixed-range up/down counter with load. It sits in the sequential counter library and serves as the tick/position counter for timers, PWM period generation and address sequencing. Beyond the plain counter it adds clamped loads, limit flags, a wrap pulse and sticky over/underflow status.

## Interface
- WIDTH, 4: counter width in bits.
- PRE_W, 8: prescaler divide-value width.
- clk  input  1  rising-edge clock, sole clock.
- rstn  input  1  reset, synchronous, active-low.
- en  input  1  count enable; a step occurs only when en=1 and prescaler tick=1.
- clr  input  1  synchronous clear to min_val; restarts prescaler.
- load_en  input  1  load request; restarts prescaler.
- load  input  WIDTH  load value.
- down  input  1  1 = decrement, 0 = increment.
- sat_mode  input  1  1 = saturate at limits, 0 = wrap.
- min_val  input  WIDTH  lower limit (unsigned).
- max_val  input  WIDTH  upper limit (unsigned).
- presc  input  PRE_W  step every presc+1 enabled cycles; 0 = every cycle.
- flag_clr  input  1  clears sticky flags.
- count  output  WIDTH  registered count.
- at_max  output  1  count == max_val (combinational from count).
- at_min  output  1  count == min_val (combinational from count).
- wrap  output  1  registered one-cycle pulse on a wrap event.
- ovf  output  1  sticky: an up step was attempted at max_val.
- unf  output  1  sticky: a down step was attempted at min_val.
- load_err  output  1  registered one-cycle pulse when a load was clamped.
- cfg_err  output  1  min_val > max_val (combinational).

## Operation
- Priority per cycle: rstn=0 > clr > load_en > step > hold.
- Reset (rstn=0 at clk edge):
  - count=0, wrap=0, ovf=0, unf=0, load_err=0, prescaler=0.
  - Reset mid-operation discards all state.
- clr: count ← min_val, prescaler ← 0, no flags.
- load_en:
  - load is clamped into [min_val, max_val] and becomes count.
  - If clamped, load_err=1 for one cycle.
  - Prescaler ← 0.
- Step (en & tick & !cfg_err):
  - Up, count < max_val: count+1.
  - Up, count == max_val: wrap mode → count ← min_val, wrap=1, ovf set. Sat mode → hold, ovf set, wrap=0.
  - Down, count > min_val: count−1.
  - Down, count == min_val: wrap mode → count ← max_val, wrap=1, unf set. Sat mode → hold, unf set.
  - If count is already out of range (limits changed at runtime), the step only clamps count to the nearer violated limit. No flags are set.
- cfg_err=1:
  - Steps are suppressed and count holds.
  - clr and load still act. Load clamps to min_val first, then max_val.
- Sticky flags are cleared by flag_clr. If set and flag_clr occur in the same cycle, set wins.
- min_val == max_val:
  - Every step is a limit hit.
  - Wrap mode: count stays, wrap pulses every step.
- Prescaler:
  - Counts enabled cycles 0..presc. tick=1 when prescaler == presc, after which it returns to 0.
  - Holds while en=0.
  - A change to presc takes effect at the next compare. If prescaler > presc, it wraps to 0 on the next enabled cycle without ticking.
- Arithmetic is unsigned modulo 2^WIDTH. Limits prevent natural overflow, except min=0/max=2^WIDTH−1, which behaves identically.

## Timing
- Registered outputs (count, wrap, ovf, unf, load_err) change one clk after the causing input.
- wrap and load_err are high exactly in the cycle count shows the wrapped or loaded value.
- With presc=N and en held high, steps occur every N+1 cycles. The first step comes N+1 cycles after clr, load or reset release.
- at_max, at_min and cfg_err are combinational, with zero latency from count and limits.

## Structure
- Package udcount_pkg:
  - step-direction constants (DIR_UP, DIR_DOWN);
  - mode constants (MODE_WRAP, MODE_SAT);
  - a clamp function (value, min, max).
- Sub-module udcount_prescaler (PRE_W; ports clk, rstn, en, restart, presc, tick).
- Top: udcount_lim, holding the priority mux, limit compare and flags.

## Test plan
- Reset/priority: WIDTH=4, assert rstn=0 together with clr and load_en → count=0, all flags 0. Release rstn with load_en=1, load=9, limits 0..15 → count=9.
- Wrap up: min=3, max=6, presc=0, up from 3 → 4,5,6,3. wrap pulses with count=3, ovf=1 stays high until flag_clr.
- Saturate down: sat_mode=1, min=2, count=2, down, en=1 for 3 cycles → count stays 2, unf=1, wrap never asserts.
- Clamped load: min=4, max=10, load=13 → count=10, load_err one cycle. load=2 → count=4, load_err. load=7 → no load_err.
- Prescaler: presc=3, en=1, up from 0 (limits 0..15) → steps at cycles 4, 8, 12. en low for 2 cycles delays the next step by 2.
- Config/runtime limits:
  - min=9, max=5 → cfg_err=1 and steps hold.
  - count=12, then max changed to 8 → next step yields count=8 with no ovf.
  - flag_clr in the same cycle as an ovf event → ovf remains 1.
